// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer driving one shared external full adder.
// Operands are shifted out LSB first and the carry is held between bits; the result is latched on entry to DONE.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c1,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             in_run;

  // The adder inputs are gated so the shared cell sees zeros while this sequencer is not using it.
  assign in_run = (state_reg == RUN);
  assign fa_a   = in_run & a_sh_reg[0];
  assign fa_b   = in_run & b_sh_reg[0];
  assign fa_c1  = in_run & carry_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum_out    <= '0;
      cout_out   <= 1'b0;
      ovf_out    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_sh_reg  <= a_in;
            b_sh_reg  <= sub ? ~b_in : b_in;
            carry_reg <= sub ? 1'b1 : cin;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          res_sh_reg <= {fa_s, res_sh_reg[WIDTH-1:1]};
          carry_reg  <= fa_c;
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            // carry_reg is the carry into the MSB during this last bit.
            sum_out   <= {fa_s, res_sh_reg[WIDTH-1:1]};
            cout_out  <= fa_c;
            ovf_out   <= carry_reg ^ fa_c;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a reference full-adder cell and a result scoreboard.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c1;
  logic             fa_s;
  logic             fa_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf_out;

  typedef struct {
    string      tag;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Reference 1-bit full adder shared with the sequencer.
  assign fa_s = fa_a ^ fa_b ^ fa_c1;
  assign fa_c = (fa_a & fa_b) | (fa_a & fa_c1) | (fa_b & fa_c1);

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c1(fa_c1), .fa_s(fa_s), .fa_c(fa_c),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level model of the operation.
  task automatic push_exp(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb_sub);
    exp_t       e;
    logic [7:0] bb;
    logic       c0;
    logic [8:0] full;
    logic [7:0] low;
    bb   = sb_sub ? ~b : b;
    c0   = sb_sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c0};
    e.tag  = tag;
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = low[7] ^ full[8];
    sb.push_back(e);
  endtask

  task automatic launch(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic s);
    a_in = a; b_in = b; cin = ci; sub = s; start = 1'b1;
    push_exp(tag, a, b, ci, s);
    tick();
    start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int n0, output int n, output int busy_cnt);
    n = n0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
  endtask

  task automatic check_result(input int n, input int busy_cnt);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_latency"}, 32'(n), 32'd9);
      chk({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
      chk({e.tag, "_sum"}, 32'(sum_out), 32'(e.sum));
      chk({e.tag, "_cout"}, 32'(cout_out), 32'(e.cout));
      chk({e.tag, "_ovf"}, 32'(ovf_out), 32'(e.ovf));
      $display("txn %s: sum=%02h cout=%0b ovf=%0b latency=%0d", e.tag, sum_out, cout_out, ovf_out, n);
    end
  endtask

  task automatic single_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic s);
    int n;
    int bc;
    launch(tag, a, b, ci, s);
    wait_done(1, n, bc);
    check_result(n, bc);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int bc;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_flags", 32'({cout_out, ovf_out}), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_c1}), 32'd0);
    rst_n = 1'b1;
    tick();

    // First RUN cycle drives operand LSBs and carry-in straight to the cell.
    launch("add_05_03", 8'h05, 8'h03, 1'b0, 1'b0);
    chk("add_05_03_fa_first", 32'({fa_a, fa_b, fa_c1}), 32'b110);
    wait_done(1, n, bc);
    check_result(n, bc);
    tick();
    chk("add_05_03_done_pulse", 32'(done), 32'd0);

    single_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    single_op("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 1'b0);
    single_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    single_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0);

    launch("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
    chk("sub_05_07_fa_c1_first", 32'(fa_c1), 32'd1);
    wait_done(1, n, bc);
    check_result(n, bc);
    tick();
    single_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1);
    single_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);

    // start held high: mid-RUN operand changes are ignored, then taken in DONE.
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    push_exp("b2b_first", 8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    a_in = 8'h55; b_in = 8'h22;
    push_exp("b2b_second", 8'h55, 8'h22, 1'b0, 1'b0);
    wait_done(1, n, bc);
    check_result(n, bc);
    tick();
    chk("b2b_done_pulse", 32'(done), 32'd0);
    chk("b2b_busy_again", 32'(busy), 32'd1);
    wait_done(1, n, bc);
    start = 1'b0;
    check_result(n, bc);
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);

    // Reset on the 4th RUN cycle aborts the operation.
    launch("abort", 8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_front());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum_out), 32'd0);
    chk("abort_fa", 32'({fa_a, fa_b, fa_c1}), 32'd0);
    done_seen = 0;
    repeat (15) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
